// File: rtl/spic_spi_master_if.sv
// Instruction handshake and result bundle between the fetch stage and the SPI back end.
interface spic_spi_master_if #(
  parameter int NSLAVES = 4,
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32
);
  localparam int INSTR_SIZE = AWIDTH + DWIDTH + 6;

  logic                  in_valid;
  logic                  in_ready;
  logic [INSTR_SIZE-1:0] in_instr;
  logic [DWIDTH-1:0]     rdata;
  logic                  rvalid;
  logic                  done;
  logic                  err;

  // Instruction source / result sink side.
  modport master (
    output in_valid, in_instr,
    input  in_ready, rdata, rvalid, done, err
  );

  // SPI back end side.
  modport slave (
    input  in_valid, in_instr,
    output in_ready, rdata, rvalid, done, err
  );
endinterface

// File: rtl/spic_spi_master.sv
// SPI mode-0 serial back end: shifts one packed instruction out to the
// selected slave and, for reads, clocks the slave's data word back in.
module spic_spi_master #(
  parameter int NSLAVES  = 4,
  parameter int AWIDTH   = 32,
  parameter int DWIDTH   = 32,
  parameter int CLK_DIV  = 2,
  parameter int TURN_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  spic_spi_master_if.slave   bus,
  output logic               sclk,
  output logic               mosi,
  input  logic               miso,
  output logic [NSLAVES-1:0] ss_n,
  output logic               busy
);
  localparam int S_ADDR_WIDTH = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam int INSTR_SIZE   = AWIDTH + DWIDTH + 6;
  localparam int S_DATA_SIZE  = INSTR_SIZE - S_ADDR_WIDTH;
  localparam int BMAX0        = (S_DATA_SIZE > DWIDTH) ? S_DATA_SIZE : DWIDTH;
  localparam int BIT_MAX      = (BMAX0 > TURN_CYC) ? BMAX0 : TURN_CYC;
  localparam int BW           = $clog2(BIT_MAX + 1);
  localparam int HW           = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, TX, TURN, RX, HOLD, GAP, ERR} state_t;

  state_t                 state_q, state_d;
  logic [S_DATA_SIZE-2:0] sr_q, sr_d;
  logic [DWIDTH-1:0]      rdata_sr_q, rdata_sr_d;
  logic [DWIDTH-1:0]      rdata_q, rdata_d;
  logic [HW-1:0]          half_q, half_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [NSLAVES-1:0]     ss_n_q, ss_n_d;
  logic                   t_type_q, t_type_d;
  logic                   sclk_q, sclk_d;
  logic                   mosi_q, mosi_d;
  logic                   in_ready_q, in_ready_d;
  logic                   busy_q, busy_d;
  logic                   rvalid_q, rvalid_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [S_ADDR_WIDTH-1:0] ss_in;
  logic [S_DATA_SIZE-1:0]  payload;
  logic                    half_last;
  logic                    rise_now;
  logic                    slot_end;

  assign ss_in     = bus.in_instr[INSTR_SIZE-1 -: S_ADDR_WIDTH];
  assign payload   = bus.in_instr[S_DATA_SIZE-1:0];
  assign half_last = (half_q == HW'(CLK_DIV - 1));
  assign rise_now  = half_last && !sclk_q;
  assign slot_end  = half_last && sclk_q;

  // Next-state logic: frame sequencing, bit-slot timing and shift registers.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    rdata_sr_d = rdata_sr_q;
    rdata_d    = rdata_q;
    half_d     = half_q;
    bit_d      = bit_q;
    ss_n_d     = ss_n_q;
    t_type_d   = t_type_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;
    rvalid_d   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (state_q == TX || state_q == TURN || state_q == RX) begin
      half_d = half_last ? '0 : half_q + 1'b1;
      if (half_last) sclk_d = ~sclk_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          if (32'(ss_in) >= NSLAVES) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d  = TX;
            sr_d     = payload[S_DATA_SIZE-2:0];
            t_type_d = payload[S_DATA_SIZE-1];
            mosi_d   = payload[S_DATA_SIZE-1];
            half_d   = '0;
            bit_d    = '0;
            sclk_d   = 1'b0;
            for (int i = 0; i < NSLAVES; i++) ss_n_d[i] = (i != int'(ss_in));
          end
        end
      end
      TX: begin
        if (slot_end) begin
          if (bit_q == BW'(S_DATA_SIZE - 1)) begin
            bit_d   = '0;
            mosi_d  = 1'b0;
            state_d = t_type_q ? HOLD : TURN;
          end else begin
            bit_d  = bit_q + 1'b1;
            mosi_d = sr_q[S_DATA_SIZE-2];
            sr_d   = {sr_q[S_DATA_SIZE-3:0], 1'b0};
          end
        end
      end
      TURN: begin
        if (slot_end) begin
          if (bit_q == BW'(TURN_CYC - 1)) begin
            bit_d   = '0;
            state_d = RX;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      RX: begin
        if (rise_now) rdata_sr_d = {rdata_sr_q[DWIDTH-2:0], miso};
        if (slot_end) begin
          if (bit_q == BW'(DWIDTH - 1)) begin
            bit_d   = '0;
            state_d = HOLD;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (half_last) begin
          state_d = GAP;
          half_d  = '0;
          ss_n_d  = '1;
          done_d  = 1'b1;
          if (!t_type_q) begin
            rvalid_d = 1'b1;
            rdata_d  = rdata_sr_q;
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      GAP: begin
        if (half_last) begin
          state_d    = IDLE;
          half_d     = '0;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      ERR: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any frame immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      rdata_sr_q <= '0;
      rdata_q    <= '0;
      half_q     <= '0;
      bit_q      <= '0;
      ss_n_q     <= '1;
      t_type_q   <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      rdata_sr_q <= rdata_sr_d;
      rdata_q    <= rdata_d;
      half_q     <= half_d;
      bit_q      <= bit_d;
      ss_n_q     <= ss_n_d;
      t_type_q   <= t_type_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      rvalid_q   <= rvalid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign sclk         = sclk_q;
  assign mosi         = mosi_q;
  assign ss_n         = ss_n_q;
  assign busy         = busy_q;
  assign bus.in_ready = in_ready_q;
  assign bus.rdata    = rdata_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
endmodule
